// File: rtl/min_queue_sorted.sv
// min_queue_sorted: register-array min priority queue kept sorted by key.
//   Head (slot 0) always holds the minimum key; equal keys keep arrival order.
//   Push, pop, and push+pop each complete in one cycle.
//   Ports: clk, rst (async, active-high), push/push_record/push_wait/full,
//          pop/pop_record/min_valid/empty, count (only with MINQ_COUNT_EN).
//   Optional feature macro: MINQ_COUNT_EN adds a registered occupancy counter.
module min_queue_sorted #(
    parameter int REC_WD  = 48,
    parameter int KEY_WD  = 16,
    parameter int Q_DEPTH = 16,
    parameter int CNT_WD  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REC_WD-1:0] push_record,
    output logic              push_wait,
    output logic              full,
    input  logic              pop,
    output logic [REC_WD-1:0] pop_record,
    output logic              min_valid,
    output logic              empty
`ifdef MINQ_COUNT_EN
    ,output logic [CNT_WD-1:0] count
`endif
);
    if (CNT_WD != $clog2(Q_DEPTH + 1) || KEY_WD > REC_WD || Q_DEPTH < 2) begin : g_bad_param
        $error("min_queue_sorted: inconsistent parameters");
    end
    logic [REC_WD-1:0]  rec_q [Q_DEPTH];
    logic [REC_WD-1:0]  rec_d [Q_DEPTH];
    logic [REC_WD-1:0]  c_rec [Q_DEPTH];
    logic [REC_WD-1:0]  p_rec [Q_DEPTH];
    logic [Q_DEPTH-1:0] vld_q, vld_d, c_vld, c_ins, p_vld, p_ins;
    logic               push_acc, pop_acc;
    assign full       = vld_q[Q_DEPTH-1];
    assign empty      = ~vld_q[0];
    assign min_valid  = vld_q[0];
    assign push_wait  = full;
    assign pop_record = rec_q[0];
    assign push_acc   = push & ~full;
    assign pop_acc    = pop & vld_q[0];
    // c_*: array contents after an accepted pop (shift down), before any insert.
    always_comb begin
        c_rec = rec_q;
        c_vld = vld_q;
        if (pop_acc) begin
            for (int i = 0; i < Q_DEPTH - 1; i++) c_rec[i] = rec_q[i + 1];
            c_rec[Q_DEPTH-1] = '0;
            c_vld = {1'b0, vld_q[Q_DEPTH-1:1]};
        end
    end
    // c_ins[i]: slot i is at or above the insert point (empty, or key strictly
    // greater). Sortedness makes this a thermometer code, so the insert point
    // is the lowest set bit and every set slot above it shifts up by one.
    always_comb begin
        for (int i = 0; i < Q_DEPTH; i++)
            c_ins[i] = ~c_vld[i] | (c_rec[i][KEY_WD-1:0] > push_record[KEY_WD-1:0]);
    end
    // p_*: the neighbour below each slot, i.e. the shift-up source.
    always_comb begin
        p_rec[0] = push_record;
        for (int i = 1; i < Q_DEPTH; i++) p_rec[i] = c_rec[i - 1];
        p_vld = {c_vld[Q_DEPTH-2:0], 1'b0};
        p_ins = {c_ins[Q_DEPTH-2:0], 1'b0};
    end
    always_comb begin
        rec_d = c_rec;
        vld_d = c_vld;
        if (push_acc) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (c_ins[i]) begin
                    rec_d[i] = p_ins[i] ? p_rec[i] : push_record;
                    vld_d[i] = p_ins[i] ? p_vld[i] : 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            rec_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            rec_q <= rec_d;
        end
    end
`ifdef MINQ_COUNT_EN
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    assign count = cnt_q;
    always_comb begin
        cnt_d = (push_acc & ~pop_acc) ? cnt_q + CNT_WD'(1) :
                (pop_acc & ~push_acc) ? cnt_q - CNT_WD'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_min_queue_sorted.sv
// tb_min_queue_sorted: self-checking bench with a sorted reference queue.
module tb_min_queue_sorted;
    localparam int D = 16;
    logic        clk, rst, push, pop;
    logic [47:0] push_record, pop_record;
    logic        push_wait, full, min_valid, empty;
`ifdef MINQ_COUNT_EN
    logic [4:0]  count;
`endif
    int checks = 0, passed = 0;
    logic [47:0] mq[$];

    min_queue_sorted #(.REC_WD(48), .KEY_WD(16), .Q_DEPTH(D), .CNT_WD(5)) dut (
        .clk(clk), .rst(rst), .push(push), .push_record(push_record),
        .push_wait(push_wait), .full(full), .pop(pop), .pop_record(pop_record),
        .min_valid(min_valid), .empty(empty)
`ifdef MINQ_COUNT_EN
        , .count(count)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic model_insert(input logic [47:0] r);
        int idx = mq.size();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i][15:0] > r[15:0]) begin
                idx = i;
                break;
            end
        mq.insert(idx, r);
    endtask

    task automatic check_state();
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("min_valid", 64'(min_valid), 64'(mq.size() != 0));
        chk("full", 64'(full), 64'(mq.size() == D));
        chk("push_wait", 64'(push_wait), 64'(mq.size() == D));
        if (mq.size() != 0) chk("head", 64'(pop_record), 64'(mq[0]));
`ifdef MINQ_COUNT_EN
        chk("count", 64'(count), 64'(mq.size()));
`endif
    endtask

    // Called at a falling edge; drives one cycle and checks after the edge.
    task automatic cycle(input logic p, input logic [47:0] r, input logic q);
        logic pa, qa;
        push = p; push_record = r; pop = q;
        pa = p && (mq.size() < D);
        qa = q && (mq.size() > 0);
        if (qa) chk("pop_out", 64'(pop_record), 64'(mq[0]));
        @(posedge clk);
        if (qa) void'(mq.pop_front());
        if (pa) model_insert(r);
        @(negedge clk);
        push = 0; pop = 0;
        check_state();
    endtask

    typedef struct {
        logic        p;
        logic        q;
        logic [47:0] rec;
        logic [47:0] exp_head;
        logic        exp_empty;
    } vec_t;
    vec_t tv[8];

    initial begin
        push = 0; pop = 0; push_record = '0; rst = 1;
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_min_valid", 64'(min_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_push_wait", 64'(push_wait), 64'd0);
        chk("rst_pop_record", 64'(pop_record), 64'd0);
`ifdef MINQ_COUNT_EN
        chk("rst_count", 64'(count), 64'd0);
`endif
        rst = 0;

        // stable ordering of equal keys
        tv[0] = '{1, 0, {32'h11, 16'd5}, {32'h11, 16'd5}, 0};
        tv[1] = '{1, 0, {32'h22, 16'd2}, {32'h22, 16'd2}, 0};
        tv[2] = '{1, 0, {32'h33, 16'd9}, {32'h22, 16'd2}, 0};
        tv[3] = '{1, 0, {32'hBB, 16'd2}, {32'h22, 16'd2}, 0};
        tv[4] = '{0, 1, 48'd0, {32'hBB, 16'd2}, 0};
        tv[5] = '{0, 1, 48'd0, {32'h11, 16'd5}, 0};
        tv[6] = '{0, 1, 48'd0, {32'h33, 16'd9}, 0};
        tv[7] = '{0, 1, 48'd0, 48'd0, 1};
        for (int i = 0; i < 8; i++) begin
            cycle(tv[i].p, tv[i].rec, tv[i].q);
            chk("tv_empty", 64'(empty), 64'(tv[i].exp_empty));
            if (!tv[i].exp_empty) chk("tv_head", 64'(pop_record), 64'(tv[i].exp_head));
        end

        // fill to capacity, reject 17th push, drain
        for (int i = 0; i < D; i++) begin
            cycle(1, {32'($urandom), 16'(100 + i)}, 0);
            chk("fill_full", 64'(full), 64'(i == D - 1));
        end
        cycle(1, {32'hDEAD, 16'd0}, 0);
        chk("rej_head_key", 64'(pop_record[15:0]), 64'd100);
        for (int i = 0; i < D; i++) begin
            chk("drain_key", 64'(pop_record[15:0]), 64'(100 + i));
            cycle(0, 48'd0, 1);
        end

        // simultaneous push+pop with new minimum
        cycle(1, {32'h3, 16'd3}, 0);
        cycle(1, {32'h7, 16'd7}, 0);
        cycle(1, {32'h8, 16'd8}, 0);
        cycle(1, {32'h1, 16'd1}, 1);
        chk("pp_head_key", 64'(pop_record[15:0]), 64'd1);
        chk("pp_size", 64'(mq.size()), 64'd3);
        cycle(0, 48'd0, 1);
        chk("pp_pop2", 64'(pop_record[15:0]), 64'd7);
        cycle(0, 48'd0, 1);
        cycle(0, 48'd0, 1);

        // pop on empty, then push
        cycle(0, 48'd0, 1);
        cycle(1, {32'h4, 16'd4}, 0);
        chk("pe_min_valid", 64'(min_valid), 64'd1);
        chk("pe_key", 64'(pop_record[15:0]), 64'd4);
        cycle(0, 48'd0, 1);

        // count sequence: push, push, push+pop, pop (model also checks count)
        cycle(1, {32'hA, 16'd10}, 0);
        cycle(1, {32'hB, 16'd11}, 0);
        cycle(1, {32'hC, 16'd12}, 1);
        cycle(0, 48'd0, 1);
        cycle(0, 48'd0, 1);

        // async reset mid-cycle with 5 records held
        for (int i = 0; i < 5; i++) cycle(1, {32'h50, 16'(20 - i)}, 0);
        #2 rst = 1;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_min_valid", 64'(min_valid), 64'd0);
        chk("arst_full", 64'(full), 64'd0);
        chk("arst_push_wait", 64'(push_wait), 64'd0);
        chk("arst_pop_record", 64'(pop_record), 64'd0);
        mq.delete();
        @(negedge clk);
        rst = 0;
        cycle(1, {32'h66, 16'd6}, 0);
        chk("post_rst_key", 64'(pop_record[15:0]), 64'd6);
        cycle(0, 48'd0, 1);

        // random traffic, small key range for many ties
        for (int i = 0; i < 400; i++) begin
            int pp = (i < 130) ? 85 : (i < 270) ? 50 : 20;
            cycle($urandom_range(0, 99) < pp, {32'($urandom), 16'($urandom_range(0, 7))},
                  $urandom_range(0, 99) >= pp);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
